// File: rtl/spike_event_if.sv
// Valid/ready event channel carrying the index of the neuron whose spike
// is offered to the shared synapse/learning datapath.
// The arbiter drives o_valid/o_id through the master modport and the
// downstream datapath returns i_ready through the slave modport.
interface spike_event_if #(
    parameter int ID_W = 3
) ();
    logic            o_valid;
    logic [ID_W-1:0] o_id;
    logic            i_ready;

    modport master (output o_valid, output o_id, input i_ready);
    modport slave  (input o_valid, input o_id, output i_ready);
endinterface

// File: rtl/spike_event_arbiter.sv
// spike_event_arbiter: latches per-neuron spike pulses into pending flags
// and serialises them round-robin onto a valid/ready event channel. Each
// accepted event produces a one-cycle one-hot pulse on o_event in the
// following cycle, so the per-neuron trace restarts in datapath order.
// Optional feature: define SPIKE_ARB_DROP_CNT_EN to count merged (lost)
// spikes in a saturating counter; otherwise o_drop_cnt is tied to zero.
module spike_event_arbiter #(
    parameter int P_N      = 8,
    parameter int P_ID_W   = 3,
    parameter int P_DROP_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [P_N-1:0]      i_spike,
    spike_event_if.master       ev,
    output logic [P_N-1:0]      o_event,
    output logic [P_N-1:0]      o_pending,
    output logic                o_busy,
    output logic [P_DROP_W-1:0] o_drop_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [P_ID_W-1:0]   id_q, id_d;
    logic [P_ID_W-1:0]   last_q, last_d;
    logic                valid_q, valid_d;
    logic [P_N-1:0]      pend_q, pend_d;
    logic [P_N-1:0]      event_q, event_d;
    logic                busy_q, busy_d;
    logic [P_N-1:0]      clr_s;
    logic [P_N-1:0]      elig_s;

    // First set bit of 'set' scanning base+1, base+2, ... modulo P_N.
    // Iterating from the farthest offset down lets the nearest one win.
    function automatic logic [P_ID_W-1:0] rr_pick(input logic [P_N-1:0]    set,
                                                  input logic [P_ID_W-1:0] base);
        logic [P_ID_W-1:0] sel;
        int                idx;
        sel = {P_ID_W{1'b0}};
        for (int k = P_N; k >= 1; k--) begin
            idx = int'(base) + k;
            if (idx >= P_N) begin
                idx = idx - P_N;
            end else begin
                idx = idx;
            end
            if (set[idx[P_ID_W-1:0]]) begin
                sel = idx[P_ID_W-1:0];
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    function automatic logic [P_N-1:0] onehot(input logic [P_ID_W-1:0] id);
        return {{(P_N-1){1'b0}}, 1'b1} << id;
    endfunction

    // Next-state, selection, pending-flag and output-register computation.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        valid_d = valid_q;
        last_d  = last_q;
        clr_s   = {P_N{1'b0}};
        elig_s  = {P_N{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    id_d    = rr_pick(pend_q, last_q);
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_OFFER: begin
                if (ev.i_ready) begin
                    clr_s  = onehot(id_q);
                    last_d = id_q;
                    // Spikes landing this cycle (including a fresh one on the
                    // accepted neuron) are candidates for the next offer.
                    elig_s = (pend_q & ~clr_s) | i_spike;
                    if (|elig_s) begin
                        id_d    = rr_pick(elig_s, id_q);
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
        // Set wins over clear: a spike in its own acceptance cycle re-arms.
        pend_d  = (pend_q & ~clr_s) | i_spike;
        event_d = clr_s;
        busy_d  = (|pend_d) | valid_d;
    end

    // State and registered-output flops; reset aborts any offer in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            id_q    <= {P_ID_W{1'b0}};
            last_q  <= P_ID_W'(P_N - 1);
            valid_q <= 1'b0;
            pend_q  <= {P_N{1'b0}};
            event_q <= {P_N{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            event_q <= event_d;
            busy_q  <= busy_d;
        end
    end

    assign ev.o_valid = valid_q;
    assign ev.o_id    = id_q;
    assign o_event    = event_q;
    assign o_pending  = pend_q;
    assign o_busy     = busy_q;

`ifdef SPIKE_ARB_DROP_CNT_EN
    logic [P_N-1:0]      drop_s;
    logic [P_DROP_W:0]   drop_sum_s;
    logic [P_DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    function automatic int popcount(input logic [P_N-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < P_N; i++) begin
            if (v[i[P_ID_W-1:0]]) begin
                n = n + 1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Saturating count of spikes merged into an already-pending flag.
    always_comb begin
        drop_s     = i_spike & pend_q & ~clr_s;
        drop_sum_s = {1'b0, drop_cnt_q} + (P_DROP_W+1)'(popcount(drop_s));
        if (drop_sum_s[P_DROP_W]) begin
            drop_cnt_d = {P_DROP_W{1'b1}};
        end else begin
            drop_cnt_d = drop_sum_s[P_DROP_W-1:0];
        end
    end

    // Drop counter register, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_cnt_q <= {P_DROP_W{1'b0}};
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = {P_DROP_W{1'b0}};
`endif

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Directed self-checking bench for spike_event_arbiter. Inputs change and
// outputs are sampled 1 ns after each rising edge; "cycle n" is the
// interval following the n-th rising edge after the reset task returns.
module tb_spike_event_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int DW = 8;
`ifdef SPIKE_ARB_DROP_CNT_EN
    localparam logic [31:0] EXP_DROP = 32'd3;
`else
    localparam logic [31:0] EXP_DROP = 32'd0;
`endif

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  spike;
    logic [N-1:0]  ev_pulse;
    logic [N-1:0]  pending;
    logic          busy;
    logic [DW-1:0] drop_cnt;
    int            n_cmp;
    int            n_err;

    spike_event_if #(.ID_W(IW)) ev_if ();

    spike_event_arbiter #(
        .P_N      (N),
        .P_ID_W   (IW),
        .P_DROP_W (DW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_spike    (spike),
        .ev         (ev_if),
        .o_event    (ev_pulse),
        .o_pending  (pending),
        .o_busy     (busy),
        .o_drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        spike = 8'h00;
        ev_if.i_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] exp_ev;
        n_cmp = 0;
        n_err = 0;

        // Reset values
        do_reset();
        check_eq("rst_valid", 32'(ev_if.o_valid), 32'd0);
        check_eq("rst_id",    32'(ev_if.o_id),    32'd0);
        check_eq("rst_event", 32'(ev_pulse),      32'd0);
        check_eq("rst_pend",  32'(pending),       32'd0);
        check_eq("rst_busy",  32'(busy),          32'd0);
        check_eq("rst_drop",  32'(drop_cnt),      32'd0);

        // Single spike on neuron 5
        spike = 8'h20; ev_if.i_ready = 1'b1;
        tick(); spike = 8'h00;
        check_eq("s5_pend_c1",  32'(pending),       32'h20);
        check_eq("s5_valid_c1", 32'(ev_if.o_valid), 32'd0);
        tick();
        check_eq("s5_valid_c2", 32'(ev_if.o_valid), 32'd1);
        check_eq("s5_id_c2",    32'(ev_if.o_id),    32'd5);
        tick();
        check_eq("s5_event_c3", 32'(ev_pulse),      32'h20);
        check_eq("s5_busy_c3",  32'(busy),          32'd0);
        check_eq("s5_valid_c3", 32'(ev_if.o_valid), 32'd0);
        tick();
        check_eq("s5_event_c4", 32'(ev_pulse),      32'd0);

        // All eight neurons at once, back-to-back grants 0..7
        do_reset();
        spike = 8'hFF; ev_if.i_ready = 1'b1;
        tick(); spike = 8'h00;
        check_eq("ff_pend", 32'(pending), 32'hFF);
        tick();
        for (int i = 0; i < 8; i++) begin
            check_eq("ff_valid", 32'(ev_if.o_valid), 32'd1);
            check_eq("ff_id",    32'(ev_if.o_id),    32'(i));
            tick();
            exp_ev = 8'h01 << i;
            check_eq("ff_event", 32'(ev_pulse), 32'(exp_ev));
        end
        check_eq("ff_valid_end", 32'(ev_if.o_valid), 32'd0);
        check_eq("ff_busy_end",  32'(busy),          32'd0);
        tick();
        check_eq("ff_event_end", 32'(ev_pulse), 32'd0);

        // Backpressure: neuron 3 held for 10 cycles
        do_reset();
        spike = 8'h08;
        tick(); spike = 8'h00;
        tick();
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_valid", 32'(ev_if.o_valid), 32'd1);
            check_eq("bp_id",    32'(ev_if.o_id),    32'd3);
            check_eq("bp_event", 32'(ev_pulse),      32'd0);
            tick();
        end
        ev_if.i_ready = 1'b1;
        tick(); ev_if.i_ready = 1'b0;
        check_eq("bp_event_rel", 32'(ev_pulse), 32'h08);
        tick();
        check_eq("bp_event_once", 32'(ev_pulse), 32'd0);

        // Round-robin: after neuron 2, spikes on 1 and 4 grant 4 first
        do_reset();
        spike = 8'h04; ev_if.i_ready = 1'b1;
        tick(); spike = 8'h00;
        tick();
        check_eq("rr_id2", 32'(ev_if.o_id), 32'd2);
        tick();
        check_eq("rr_event2", 32'(ev_pulse), 32'h04);
        spike = 8'h12;
        tick(); spike = 8'h00;
        tick();
        check_eq("rr_first",  32'(ev_if.o_id), 32'd4);
        tick();
        check_eq("rr_second", 32'(ev_if.o_id), 32'd1);
        check_eq("rr_event4", 32'(ev_pulse),   32'h10);
        tick();
        check_eq("rr_event1", 32'(ev_pulse),   32'h02);

        // Merged spikes on neuron 6, then spike in its own acceptance cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            spike = 8'h40;
            tick();
        end
        spike = 8'h00;
        check_eq("drop_cnt3", 32'(drop_cnt),   EXP_DROP);
        check_eq("drop_id6",  32'(ev_if.o_id), 32'd6);
        tick();
        ev_if.i_ready = 1'b1; spike = 8'h40;
        tick();
        ev_if.i_ready = 1'b0; spike = 8'h00;
        check_eq("rearm_pend",  32'(pending),       32'h40);
        check_eq("rearm_event", 32'(ev_pulse),      32'h40);
        check_eq("rearm_drop",  32'(drop_cnt),      EXP_DROP);
        check_eq("rearm_valid", 32'(ev_if.o_valid), 32'd1);

        // Reset asserted mid-offer
        do_reset();
        spike = 8'h02;
        tick(); spike = 8'h00;
        tick();
        check_eq("ro_valid_pre", 32'(ev_if.o_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("ro_valid", 32'(ev_if.o_valid), 32'd0);
        check_eq("ro_id",    32'(ev_if.o_id),    32'd0);
        check_eq("ro_pend",  32'(pending),       32'd0);
        check_eq("ro_busy",  32'(busy),          32'd0);
        @(negedge clk);
        rst_n = 1'b1; ev_if.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("ro_event_post", 32'(ev_pulse),      32'd0);
            check_eq("ro_valid_post", 32'(ev_if.o_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
